shift_pipe: RTL
===============

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data path width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHAMT_W, default 8: shift amount input width; SHALL be >= $clog2(WIDTH)+1.
REQ-003 Parameter TAG_W, default 4: opaque tag width, e.g. destination register index.
REQ-004 Port clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port flush  input  1: synchronous discard of all in-flight operations.
REQ-007 Port in_valid  input  1, in_ready  output  1: request handshake.
REQ-008 Port in_data  input  WIDTH: operand to shift.
REQ-009 Port in_shamt  input  SHAMT_W: unsigned shift amount.
REQ-010 Port in_op  input  2: shift operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-011 Port in_tag  input  TAG_W: tag carried unchanged alongside the operation.
REQ-012 Port out_valid  output  1, out_ready  input  1: result handshake.
REQ-013 Port out_data  output  WIDTH; out_tag  output  TAG_W.
REQ-014 Port out_zero, out_neg, out_carry  output  1 each: result flags.

Function
REQ-015 A transfer SHALL occur on a cycle with valid and ready both high; there SHALL be no other transfers.
REQ-016 Two register stages: stage 1 applies saturation and the coarse shift (shamt bits above log2(WIDTH)/2); stage 2 applies the fine shift and computes the flags.
REQ-017 Latency SHALL be 2 cycles: a transfer accepted at edge N presents out_valid at edge N+2 when there is no stall.
REQ-018 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-019 Stall rules: stage 2 holds while out_valid=1 and out_ready=0; stage 1 advances only when stage 2 is empty or draining; in_ready = !s1_valid OR stage 1 advancing (combinational path from out_ready allowed).
REQ-020 While stalled, out_data/out_tag/flags SHALL stay stable.
REQ-021 Results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-022 Saturation, shamt >= WIDTH: LSL/LSR yield 0; ASR yields all copies of the sign bit; ROR uses shamt mod WIDTH.
REQ-023 shamt=0: out_data=in_data and carry=0 for all ops.
REQ-024 Carry for k=shamt, 1<=k<=WIDTH: LSL in_data[WIDTH-k]; LSR/ASR in_data[k-1]; ROR out_data[WIDTH-1].
REQ-025 Carry for k>WIDTH: LSL/LSR give 0; ASR gives the sign bit; ROR follows REQ-024 on the reduced amount.
REQ-026 out_zero = (out_data==0); out_neg = out_data[WIDTH-1].
REQ-027 Flush: both stage valids SHALL clear at the edge; out_valid=0 on the following cycle; in_ready=0 while flush=1, so nothing is accepted.
REQ-028 Reset SHALL take priority over flush and over handshakes.

Reset
REQ-029 On reset: s1_valid=0, s2_valid=0, out_valid=0, in_ready=0 during reset, and =1 on the first cycle after.
REQ-030 On reset: out_data, out_tag and all flags SHALL be 0.
REQ-031 Reset mid-operation SHALL discard in-flight ops; no result from them SHALL appear afterwards.

Configuration
REQ-032 Macro SHIFT_PIPE_CARRY_EN: when defined, out_carry SHALL follow REQ-024/025.
REQ-033 When SHIFT_PIPE_CARRY_EN is undefined, out_carry SHALL be tied to 0 and no carry logic or register SHALL be synthesised; all other behaviour is unchanged.

Structure
REQ-034 Package shifter_pkg SHALL hold the shift_op_t enum (LSL, LSR, ASR, ROR codes) and the flag bundle typedef; the codebase Shifter SHALL use the same codes.
REQ-035 One sub-module, shift_pipe_reg: a single valid/ready pipeline register with flush, instantiated twice.

Verification (WIDTH=16, CARRY_EN defined)
REQ-036 LSL 0x8001 by 1, out_ready=1 -> 2 cycles later: 0x0002, carry=1, zero=0, neg=0, tag echoed.
REQ-037 ASR 0x8000 by 20 -> 0xFFFF, carry=1, neg=1; LSR 0x8000 by 20 -> 0x0000, zero=1, carry=0.
REQ-038 ROR 0x0001 by 17 -> 0x8000, carry=1; ROR 0x1234 by 0 -> 0x1234, carry=0.
REQ-039 Backpressure: 5 back-to-back ops with tags 0..4; out_ready low for 4 cycles -> in_ready drops once both stages are full; all 5 results out in order with stable data while stalled.
REQ-040 Flush with 2 ops in flight -> out_valid=0 next cycle and the flushed tags never appear; the next op completes in 2 cycles.
REQ-041 Reset asserted with 2 ops in flight -> all outputs 0 and in_ready=0 during reset; in_ready=1 after; no stale results.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared shift operation codes and result flag bundle for the shifter datapath.
package shifter_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_op_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
    } shift_flags_t;

endpackage

// File: rtl/shift_pipe_reg.sv
// One valid/ready pipeline register with synchronous flush.
// A transfer happens only on a cycle where valid and ready are both high; reset beats flush beats transfers.
module shift_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid;
    logic [W-1:0] data;

    assign in_ready  = !reset && !flush && (!valid || out_ready);
    assign out_valid = valid;
    assign out_data  = data;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else begin
            if (!valid || out_ready) begin
                valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage barrel shifter: stage 1 saturates and coarse-shifts, stage 2 fine-shifts and sets flags.
// Define SHIFT_PIPE_CARRY_EN to build the carry flag; otherwise out_carry is tied to 0.
module shift_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 8,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero,
    output logic               out_neg,
    output logic               out_carry
);

    localparam int LOG    = $clog2(WIDTH);
    localparam int FINE_W = LOG / 2;
`ifdef SHIFT_PIPE_CARRY_EN
    localparam int CARRY_W = 1;
`else
    localparam int CARRY_W = 0;
`endif
    localparam int S1_W = WIDTH + 2 + FINE_W + TAG_W + CARRY_W;
    localparam int S2_W = WIDTH + TAG_W + 2 + CARRY_W;

    shift_op_t                op_in;
    logic                     sat;
    logic [LOG-1:0]           coarse;
    logic [2*WIDTH-1:0]       rot_c;
    logic signed [WIDTH-1:0]  asr_c;
    logic [WIDTH-1:0]         c1_data;
    logic [FINE_W-1:0]        c1_fine;
    logic [S1_W-1:0]          s1_in;
    logic [S1_W-1:0]          s1_out;
    logic                     s1_valid;
    logic                     s2_in_ready;

    assign op_in = shift_op_t'(in_op);

    // Saturated LSL/LSR/ASR leave nothing for the fine stage; ROR just wraps.
    always_comb begin
        sat     = |in_shamt[SHAMT_W-1:LOG];
        coarse  = {in_shamt[LOG-1:FINE_W], {FINE_W{1'b0}}};
        rot_c   = {in_data, in_data} >> coarse;
        asr_c   = $signed(in_data) >>> coarse;
        c1_fine = in_shamt[FINE_W-1:0];
        c1_data = in_data;
        case (op_in)
            LSL:     c1_data = sat ? '0 : (in_data << coarse);
            LSR:     c1_data = sat ? '0 : (in_data >> coarse);
            ASR:     c1_data = sat ? {WIDTH{in_data[WIDTH-1]}} : asr_c;
            default: c1_data = rot_c[WIDTH-1:0];
        endcase
        if (sat && op_in != ROR) begin
            c1_fine = '0;
        end
    end

`ifdef SHIFT_PIPE_CARRY_EN
    logic [WIDTH:0]          lsl_x;
    logic [WIDTH:0]          lsr_x;
    logic signed [WIDTH:0]   asr_x;
    logic [2*WIDTH-1:0]      rot_x;
    logic                    c1_carry;

    // A guard bit beside the operand catches the last bit shifted out over the full amount.
    always_comb begin
        lsl_x = {1'b0, in_data} << in_shamt;
        lsr_x = {in_data, 1'b0} >> in_shamt;
        asr_x = $signed({in_data, 1'b0}) >>> in_shamt;
        rot_x = {in_data, in_data} >> in_shamt[LOG-1:0];
        case (op_in)
            LSL:     c1_carry = lsl_x[WIDTH];
            LSR:     c1_carry = lsr_x[0];
            ASR:     c1_carry = asr_x[0];
            default: c1_carry = (|in_shamt) & rot_x[WIDTH-1];
        endcase
    end

    assign s1_in = {c1_carry, c1_data, in_op, c1_fine, in_tag};
`else
    assign s1_in = {c1_data, in_op, c1_fine, in_tag};
`endif

    shift_pipe_reg #(.W(S1_W)) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_out)
    );

    logic [WIDTH-1:0]        s1_data;
    shift_op_t               s1_op;
    logic [FINE_W-1:0]       s1_fine;
    logic [TAG_W-1:0]        s1_tag;
    logic [2*WIDTH-1:0]      rot_f;
    logic signed [WIDTH-1:0] asr_f;
    logic [WIDTH-1:0]        c2_data;
    shift_flags_t            c2_flags;
    logic [S2_W-1:0]         s2_in;
    logic [S2_W-1:0]         s2_out;
    shift_flags_t            s2_flags;

    assign s1_tag  = s1_out[TAG_W-1:0];
    assign s1_fine = s1_out[TAG_W +: FINE_W];
    assign s1_op   = shift_op_t'(s1_out[TAG_W+FINE_W +: 2]);
    assign s1_data = s1_out[TAG_W+FINE_W+2 +: WIDTH];

    always_comb begin
        rot_f = {s1_data, s1_data} >> s1_fine;
        asr_f = $signed(s1_data) >>> s1_fine;
        case (s1_op)
            LSL:     c2_data = s1_data << s1_fine;
            LSR:     c2_data = s1_data >> s1_fine;
            ASR:     c2_data = asr_f;
            default: c2_data = rot_f[WIDTH-1:0];
        endcase
        c2_flags.zero  = (c2_data == '0);
        c2_flags.neg   = c2_data[WIDTH-1];
`ifdef SHIFT_PIPE_CARRY_EN
        c2_flags.carry = s1_out[S1_W-1];
`else
        c2_flags.carry = 1'b0;
`endif
    end

`ifdef SHIFT_PIPE_CARRY_EN
    assign s2_in = {c2_flags.carry, c2_flags.zero, c2_flags.neg, s1_tag, c2_data};
`else
    assign s2_in = {c2_flags.zero, c2_flags.neg, s1_tag, c2_data};
`endif

    shift_pipe_reg #(.W(S2_W)) u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign s2_flags.neg  = s2_out[WIDTH+TAG_W];
    assign s2_flags.zero = s2_out[WIDTH+TAG_W+1];
`ifdef SHIFT_PIPE_CARRY_EN
    assign s2_flags.carry = s2_out[S2_W-1];
`else
    assign s2_flags.carry = 1'b0;
`endif

    assign out_data  = s2_out[WIDTH-1:0];
    assign out_tag   = s2_out[WIDTH +: TAG_W];
    assign out_zero  = s2_flags.zero;
    assign out_neg   = s2_flags.neg;
    assign out_carry = s2_flags.carry;

endmodule
